// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register built as a two-entry elastic stage (main + skid).
// The main register drives EXE directly; the skid register absorbs one extra instruction under backpressure.
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 12,
  parameter int OPC_W  = 5,
  parameter int RD_W   = 4,
  parameter int CMD_W  = 3,
  parameter logic [OPC_W-1:0] NOP_OPCODE = '0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_valid,
  output logic              ID_ready,
  input  logic [DATA_W-1:0] ID_A,
  input  logic [DATA_W-1:0] ID_B,
  input  logic [IMM_W-1:0]  ID_immed,
  input  logic [OPC_W-1:0]  ID_Opcode,
  input  logic [RD_W-1:0]   ID_Rd_num,
  input  logic [CMD_W-1:0]  ID_I_cmd,
  input  logic              ID_S,
  input  logic              ID_in_sel,
  input  logic              flush,
  input  logic              EXE_ready,
  output logic              EXE_valid,
  output logic [DATA_W-1:0] EXE_In,
  output logic [DATA_W-1:0] EXE_A,
  output logic [DATA_W-1:0] EXE_B,
  output logic [IMM_W-1:0]  EXE_immed,
  output logic [OPC_W-1:0]  EXE_Opcode,
  output logic [RD_W-1:0]   EXE_Rd_num,
  output logic [CMD_W-1:0]  EXE_I_cmd,
  output logic              EXE_S,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
  // and ID_ready is a function of registered state only.
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t state;
  state_t state_next;
  logic   out_of_reset;
  logic   in_xfer;
  logic   out_xfer;
  logic   load_main_id;
  logic   load_main_skid;
  logic   load_skid;

  logic [DATA_W-1:0] skid_in;
  logic [DATA_W-1:0] skid_a;
  logic [DATA_W-1:0] skid_b;
  logic [IMM_W-1:0]  skid_immed;
  logic [OPC_W-1:0]  skid_opcode;
  logic [RD_W-1:0]   skid_rd_num;
  logic [CMD_W-1:0]  skid_i_cmd;
  logic              skid_s;
  logic [OPC_W-1:0]  main_opcode;

  // out_of_reset keeps ID_ready low while reset is held and rises on the first edge after release.
  assign ID_ready   = out_of_reset && (state != SKID);
  assign EXE_valid  = (state != EMPTY);
  assign EXE_Opcode = EXE_valid ? main_opcode : NOP_OPCODE;
  assign in_xfer    = ID_valid && ID_ready;
  assign out_xfer   = EXE_valid && EXE_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_next;
      out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    load_main_id   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_main_id = 1'b1;
            state_next   = FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            load_main_id = 1'b1;
          end else if (in_xfer) begin
            load_skid  = 1'b1;
            state_next = SKID;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        SKID: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_next     = FULL;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Main register: data fields keep their last values when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EXE_In      <= '0;
      EXE_A       <= '0;
      EXE_B       <= '0;
      EXE_immed   <= '0;
      main_opcode <= '0;
      EXE_Rd_num  <= '0;
      EXE_I_cmd   <= '0;
      EXE_S       <= 1'b0;
    end else if (load_main_id) begin
      EXE_In      <= ID_in_sel ? ID_B : ID_A;
      EXE_A       <= ID_A;
      EXE_B       <= ID_B;
      EXE_immed   <= ID_immed;
      main_opcode <= ID_Opcode;
      EXE_Rd_num  <= ID_Rd_num;
      EXE_I_cmd   <= ID_I_cmd;
      EXE_S       <= ID_S;
    end else if (load_main_skid) begin
      EXE_In      <= skid_in;
      EXE_A       <= skid_a;
      EXE_B       <= skid_b;
      EXE_immed   <= skid_immed;
      main_opcode <= skid_opcode;
      EXE_Rd_num  <= skid_rd_num;
      EXE_I_cmd   <= skid_i_cmd;
      EXE_S       <= skid_s;
    end
  end

  // The In operand is resolved on capture so the skid entry carries its own selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_in     <= '0;
      skid_a      <= '0;
      skid_b      <= '0;
      skid_immed  <= '0;
      skid_opcode <= '0;
      skid_rd_num <= '0;
      skid_i_cmd  <= '0;
      skid_s      <= 1'b0;
    end else if (load_skid) begin
      skid_in     <= ID_in_sel ? ID_B : ID_A;
      skid_a      <= ID_A;
      skid_b      <= ID_B;
      skid_immed  <= ID_immed;
      skid_opcode <= ID_Opcode;
      skid_rd_num <= ID_Rd_num;
      skid_i_cmd  <= ID_I_cmd;
      skid_s      <= ID_S;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!EXE_valid && EXE_ready && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
